// File: rtl/fp_sqrt_iter_if.sv
// Handshake bundle for fp_sqrt_iter: operand channel (a, round) and result channel (z, status).
interface fp_sqrt_iter_if #(
   parameter int sig_width = 23,
   parameter int ex_width  = 8
);
   logic                        in_valid;
   logic                        in_ready;
   logic [sig_width+ex_width:0] a;
   logic [2:0]                  round;
   logic                        out_valid;
   logic                        out_ready;
   logic [sig_width+ex_width:0] z;
   logic [7:0]                  status;

   modport master (
      output in_valid, a, round, out_ready,
      input  in_ready, out_valid, z, status
   );

   modport slave (
      input  in_valid, a, round, out_ready,
      output in_ready, out_valid, z, status
   );
endinterface

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754 square root, restoring recurrence, bits_per_cycle root bits per cycle.
// Define FP_SQRT_ITER_BACK_TO_BACK_EN to allow a new accept in the same cycle as a result transfer.
module fp_sqrt_iter #(
   parameter int sig_width      = 23,
   parameter int ex_width       = 8,
   parameter int bits_per_cycle = 1
) (
   input logic           clk,
   input logic           reset,
   input logic           enable,
   fp_sqrt_iter_if.slave bus
);
   localparam int W  = sig_width + ex_width + 1;
   localparam int N  = (sig_width + 3 + bits_per_cycle - 1) / bits_per_cycle;
   localparam int Q  = N * bits_per_cycle;
   localparam int DW = 2 * Q;
   localparam int RW = Q + 3;
   localparam int CW = $clog2(N + 1);
   localparam logic [W-1:0] QNAN = {1'b0, {ex_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
   localparam logic [W-1:0] PINF = {1'b0, {ex_width{1'b1}}, {sig_width{1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
   state_t state_reg, state_next;

   logic [CW-1:0]       cnt_reg;
   logic [2:0]          round_reg;
   logic [ex_width-1:0] exp_reg;
   logic [RW-1:0]       rem_reg;
   logic [Q-1:0]        root_reg;
   logic [DW-1:0]       rad_reg;
   logic [W-1:0]        z_reg;
   logic [7:0]          status_reg;

   logic                 a_sign;
   logic [ex_width-1:0]  a_exp;
   logic [sig_width-1:0] a_sig;
   logic                 exp_ones, exp_zero, sig_zero;
   logic                 exc;
   logic [W-1:0]         exc_z;
   logic [7:0]           exc_status;
   logic [ex_width:0]    exp_sum;
   logic [sig_width+1:0] mant_x;
   logic                 accept, xfer;

   assign a_sign   = bus.a[W-1];
   assign a_exp    = bus.a[sig_width +: ex_width];
   assign a_sig    = bus.a[sig_width-1:0];
   assign exp_ones = &a_exp;
   assign exp_zero = (a_exp == '0);
   assign sig_zero = (a_sig == '0);

   // (E + bias) / 2 is the biased result exponent; its LSB flags an odd unbiased exponent.
   assign exp_sum = {1'b0, a_exp} + {2'b00, {(ex_width-1){1'b1}}};
   assign mant_x  = exp_sum[0] ? {1'b1, a_sig, 1'b0} : {2'b01, a_sig};

   always_comb begin
      exc        = 1'b1;
      exc_z      = '0;
      exc_status = '0;
      if (exp_ones && !sig_zero) begin
         exc_z      = QNAN;
         exc_status = 8'h04;
      end else if (a_sign && !(exp_zero && sig_zero)) begin
         exc_z      = QNAN;
         exc_status = 8'h04;
      end else if (exp_ones) begin
         exc_z      = PINF;
         exc_status = 8'h02;
      end else if (exp_zero) begin
         exc_z      = {a_sign, {(W-1){1'b0}}};
         exc_status = 8'h01;
      end else begin
         exc = 1'b0;
      end
   end

   logic [RW-1:0] rem_s  [bits_per_cycle+1];
   logic [Q-1:0]  root_s [bits_per_cycle+1];
   logic [DW-1:0] rad_s  [bits_per_cycle+1];

   assign rem_s[0]  = rem_reg;
   assign root_s[0] = root_reg;
   assign rad_s[0]  = rad_reg;

   generate
      for (genvar gi = 0; gi < bits_per_cycle; gi++) begin : g_step
         logic [RW-1:0] shifted, trial;
         logic          fits;
         assign shifted        = {rem_s[gi][RW-3:0], rad_s[gi][DW-1 -: 2]};
         assign trial          = {1'b0, root_s[gi], 2'b01};
         assign fits           = (shifted >= trial);
         assign rem_s[gi+1]    = fits ? (shifted - trial) : shifted;
         assign root_s[gi+1]   = {root_s[gi][Q-2:0], fits};
         assign rad_s[gi+1]    = {rad_s[gi][DW-3:0], 2'b00};
      end
   endgenerate

   logic [sig_width:0]   kept;
   logic                 guard, sticky, inc;
   logic [sig_width+1:0] sum;
   logic [sig_width-1:0] frac;
   logic [ex_width-1:0]  exp_rnd;

   // The root is always positive, so +inf behaves like away-from-zero and -inf like truncation.
   always_comb begin
      kept   = root_reg[Q-1 -: sig_width+1];
      guard  = root_reg[Q-2-sig_width];
      sticky = (|root_reg[Q-3-sig_width:0]) | (|rem_reg);
      inc    = 1'b0;
      case (round_reg)
         3'd1, 3'd3: inc = 1'b0;
         3'd2, 3'd5: inc = guard | sticky;
         3'd4:       inc = guard;
         default:    inc = guard & (sticky | kept[0]);
      endcase
      sum     = {1'b0, kept} + {{(sig_width+1){1'b0}}, inc};
      frac    = sum[sig_width+1] ? sum[sig_width:1] : sum[sig_width-1:0];
      exp_rnd = exp_reg + {{(ex_width-1){1'b0}}, sum[sig_width+1]};
   end

`ifdef FP_SQRT_ITER_BACK_TO_BACK_EN
   assign bus.in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
`else
   assign bus.in_ready = (state_reg == IDLE);
`endif
   assign bus.out_valid = (state_reg == DONE);
   assign bus.z         = z_reg;
   assign bus.status    = status_reg;
   assign accept        = enable & bus.in_valid & bus.in_ready;
   assign xfer          = enable & bus.out_valid & bus.out_ready;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = exc ? DONE : CALC;
         CALC:    if (enable && cnt_reg == '0) state_next = ROUND;
         ROUND:   if (enable) state_next = DONE;
         DONE: begin
            if (accept)    state_next = exc ? DONE : CALC;
            else if (xfer) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else if (enable) state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg    <= '0;
         round_reg  <= '0;
         exp_reg    <= '0;
         rem_reg    <= '0;
         root_reg   <= '0;
         rad_reg    <= '0;
         z_reg      <= '0;
         status_reg <= '0;
      end else if (enable) begin
         if (accept) begin
            round_reg <= bus.round;
            exp_reg   <= exp_sum[ex_width:1];
            rem_reg   <= '0;
            root_reg  <= '0;
            rad_reg   <= {mant_x, {(DW-sig_width-2){1'b0}}};
            cnt_reg   <= CW'(N - 1);
            if (exc) begin
               z_reg      <= exc_z;
               status_reg <= exc_status;
            end
         end else if (state_reg == CALC) begin
            rem_reg  <= rem_s[bits_per_cycle];
            root_reg <= root_s[bits_per_cycle];
            rad_reg  <= rad_s[bits_per_cycle];
            if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
         end else if (state_reg == ROUND) begin
            z_reg      <= {1'b0, exp_rnd, frac};
            status_reg <= {2'b00, guard | sticky, 5'b00000};
         end
      end
   end
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Self-checking bench for fp_sqrt_iter: vector table through a scoreboard plus stall/reset/backpressure sequences.
`timescale 1ns/1ps
module tb_fp_sqrt_iter;
`ifdef FP_SQRT_ITER_BACK_TO_BACK_EN
   localparam int BPC = 2;
`else
   localparam int BPC = 1;
`endif
   localparam int NIT = (23 + 3 + BPC - 1) / BPC;
   localparam int LAT = NIT + 2;
   localparam int NV  = 22;

   typedef struct {
      logic [31:0] a;
      logic [2:0]  rnd;
      logic [31:0] z;
      logic [7:0]  st;
      bit          exc;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] z;
      logic [7:0]  st;
      int          acc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_res = 0;
   exp_t sb[$];
   int   arr_q[$];
   vec_t tbl [NV];

   fp_sqrt_iter_if #(.sig_width(23), .ex_width(8)) bif ();

   fp_sqrt_iter #(.sig_width(23), .ex_width(8), .bits_per_cycle(BPC)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endfunction

   // Result monitor: pops the scoreboard on every output transfer.
   bit prev_valid = 1'b0;
   int first_valid = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (bif.out_valid && !prev_valid) first_valid = cyc;
         if (bif.out_valid && bif.out_ready && enable) begin
            n_res++;
            arr_q.push_back(first_valid);
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: got z=%h, expected no result", bif.z);
            end else begin
               e = sb.pop_front();
               $display("result a=%h round=%0d z=%h status=%h latency=%0d",
                        e.a, dut.round_reg, bif.z, bif.status, first_valid - e.acc);
               chk("z", bif.z, e.z);
               chk("status", {24'h0, bif.status}, {24'h0, e.st});
               chk("latency", first_valid - e.acc, e.lat);
`ifdef FP_SQRT_ITER_BACK_TO_BACK_EN
               chk("in_ready_done", {31'h0, bif.in_ready}, 32'd1);
`else
               chk("in_ready_done", {31'h0, bif.in_ready}, 32'd0);
`endif
            end
            prev_valid = 1'b0;
         end else begin
            prev_valid = bif.out_valid;
         end
      end
   end

   task automatic send(input vec_t v, input int lat, input bit track);
      int b = 0;
      @(negedge clk);
      bif.in_valid = 1'b1;
      bif.a        = v.a;
      bif.round    = v.rnd;
      while (!(bif.in_ready && enable) && b < 300) begin
         @(negedge clk);
         b++;
      end
      if (b >= 300) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=%b, expected 1", bif.in_ready);
      end else if (track) begin
         sb.push_back('{v.a, v.z, v.st, cyc, lat});
      end
      @(posedge clk);
      #1 bif.in_valid = 1'b0;
   endtask

   task automatic drain();
      int b = 0;
      while (sb.size() != 0 && b < 300) begin
         @(negedge clk);
         b++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{32'h40800000, 3'd0, 32'h40000000, 8'h00, 1'b0};
      tbl[1]  = '{32'h40000000, 3'd0, 32'h3FB504F3, 8'h20, 1'b0};
      tbl[2]  = '{32'h40000000, 3'd1, 32'h3FB504F3, 8'h20, 1'b0};
      tbl[3]  = '{32'h40000000, 3'd2, 32'h3FB504F4, 8'h20, 1'b0};
      tbl[4]  = '{32'h40000000, 3'd3, 32'h3FB504F3, 8'h20, 1'b0};
      tbl[5]  = '{32'h40000000, 3'd4, 32'h3FB504F3, 8'h20, 1'b0};
      tbl[6]  = '{32'h40000000, 3'd5, 32'h3FB504F4, 8'h20, 1'b0};
      tbl[7]  = '{32'h41100000, 3'd0, 32'h40400000, 8'h00, 1'b0};
      tbl[8]  = '{32'h3E800000, 3'd0, 32'h3F000000, 8'h00, 1'b0};
      tbl[9]  = '{32'h40400000, 3'd0, 32'h3FDDB3D7, 8'h20, 1'b0};
      tbl[10] = '{32'h40400000, 3'd2, 32'h3FDDB3D8, 8'h20, 1'b0};
      tbl[11] = '{32'h7F7FFFFF, 3'd0, 32'h5F7FFFFF, 8'h20, 1'b0};
      tbl[12] = '{32'h7F7FFFFF, 3'd2, 32'h5F800000, 8'h20, 1'b0};
      tbl[13] = '{32'h00800000, 3'd0, 32'h20000000, 8'h00, 1'b0};
      tbl[14] = '{32'h3F800000, 3'd0, 32'h3F800000, 8'h00, 1'b0};
      tbl[15] = '{32'hBF800000, 3'd0, 32'h7FC00000, 8'h04, 1'b1};
      tbl[16] = '{32'h7F800000, 3'd0, 32'h7F800000, 8'h02, 1'b1};
      tbl[17] = '{32'h80000000, 3'd0, 32'h80000000, 8'h01, 1'b1};
      tbl[18] = '{32'h00000001, 3'd0, 32'h00000000, 8'h01, 1'b1};
      tbl[19] = '{32'h7FC00001, 3'd0, 32'h7FC00000, 8'h04, 1'b1};
      tbl[20] = '{32'hFF800000, 3'd0, 32'h7FC00000, 8'h04, 1'b1};
      tbl[21] = '{32'h00000000, 3'd0, 32'h00000000, 8'h01, 1'b1};

      reset         = 1'b1;
      enable        = 1'b1;
      bif.in_valid  = 1'b0;
      bif.a         = '0;
      bif.round     = '0;
      bif.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", {31'h0, bif.in_ready}, 32'd1);
      chk("reset_out_valid", {31'h0, bif.out_valid}, 32'd0);
      chk("reset_z", bif.z, 32'h0);
      chk("reset_status", {24'h0, bif.status}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         send(tbl[i], tbl[i].exc ? 1 : LAT, 1'b1);
         drain();
      end

      // Backpressure: result must hold steady while the consumer stalls.
      begin
         int b = 0;
         @(negedge clk);
         bif.out_ready = 1'b0;
         send(tbl[0], LAT, 1'b1);
         while (!bif.out_valid && b < 300) begin
            @(negedge clk);
            b++;
         end
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'h0, bif.out_valid}, 32'd1);
            chk("hold_z", bif.z, 32'h40000000);
            chk("hold_status", {24'h0, bif.status}, 32'h0);
            chk("hold_in_ready", {31'h0, bif.in_ready}, 32'd0);
         end
         bif.out_ready = 1'b1;
         drain();
      end

      // Global stall mid-CALC stretches latency by exactly the stall length.
      send(tbl[1], LAT + 3, 1'b1);
      repeat (5) @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      drain();

      // Reset mid-CALC aborts without producing a result.
      send(tbl[0], LAT, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_out_valid", {31'h0, bif.out_valid}, 32'd0);
      chk("abort_in_ready", {31'h0, bif.in_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      send(tbl[0], LAT, 1'b1);
      drain();

`ifdef FP_SQRT_ITER_BACK_TO_BACK_EN
      begin
         int k = 0;
         int b = 0;
         int res0;
         int idx[6] = '{0, 1, 3, 7, 9, 11};
         arr_q.delete();
         res0 = n_res;
         while (k < 6 && b < 400) begin
            @(negedge clk);
            bif.in_valid = 1'b1;
            bif.a        = tbl[idx[k]].a;
            bif.round    = tbl[idx[k]].rnd;
            if (bif.in_ready && enable) begin
               sb.push_back('{tbl[idx[k]].a, tbl[idx[k]].z, tbl[idx[k]].st, cyc, LAT});
               k++;
            end
            b++;
         end
         @(posedge clk);
         #1 bif.in_valid = 1'b0;
         drain();
         chk("b2b_accepts", k, 6);
         chk("b2b_results", n_res - res0, 6);
         for (int i = 1; i < arr_q.size(); i++)
            chk("b2b_spacing", arr_q[i] - arr_q[i-1], LAT);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
